// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU. Single-cycle ops go straight to HOLD; MUL runs an
// iterative shift-add engine, one multiplier bit per cycle, before reaching HOLD.
//
// state | meaning
// IDLE  | nothing held, ready for a request
// MUL   | shift-add multiply in progress
// HOLD  | RESULT/FLAGS valid, waiting for out_ready
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       OPCODE,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RESULT,
  output logic [3:0]       FLAGS
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t             state, state_nxt;
  logic               accept, is_mul, cnt_last;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [3:0]         alu_flags;
  logic [WIDTH:0]     sum_ext, dif_ext, shl_ext, shr_ext;
  logic               sh_big, sh_eq;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (OPCODE == OP_MUL);
  assign cnt_last  = (cnt == CNT_LAST);

  // Extended operands expose the carry/borrow and the last bit shifted out.
  assign sum_ext = {1'b0, OP1} + {1'b0, OP2};
  assign dif_ext = {1'b0, OP1} - {1'b0, OP2};
  assign shl_ext = {1'b0, OP1} << OP2[SHW-1:0];
  assign shr_ext = {OP1, 1'b0} >> OP2[SHW-1:0];
  assign sh_big  = (OP2 >= W_VAL);
  assign sh_eq   = (OP2 == W_VAL);

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OPCODE)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum_ext[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (dif_ext[WIDTH-1] != OP1[WIDTH-1]);
      end
      OP_AND: alu_res = OP1 & OP2;
      OP_OR:  alu_res = OP1 | OP2;
      OP_XOR: alu_res = OP1 ^ OP2;
      OP_SHL: begin
        alu_res = sh_big ? '0 : shl_ext[WIDTH-1:0];
        alu_c   = sh_big ? (sh_eq && OP1[0]) : shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = sh_big ? '0 : shr_ext[WIDTH:1];
        alu_c   = sh_big ? (sh_eq && OP1[WIDTH-1]) : shr_ext[0];
      end
      default: ;
    endcase
  end

  assign alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul ? MUL : HOLD;
      MUL:     if (cnt_last) state_nxt = HOLD;
      HOLD: begin
        if (accept)         state_nxt = is_mul ? MUL : HOLD;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      RESULT <= '0;
      FLAGS  <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (is_mul) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, OP1};
          mplier <= OP2;
          cnt    <= '0;
        end else begin
          RESULT <= alu_res;
          FLAGS  <= alu_flags;
        end
      end else if (state == MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt_last) begin
          RESULT <= acc_nxt[WIDTH-1:0];
          FLAGS  <= {(acc_nxt[WIDTH-1:0] == '0), acc_nxt[WIDTH-1], 1'b0,
                     |acc_nxt[2*WIDTH-1:WIDTH]};
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=4); expected results are
// queued at accept and compared when the DUT hands a result over.
module tb_alu_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   opcode;
  logic [W-1:0] op1, op2, result;
  logic [3:0]   flags;

  int n_chk = 0;
  int n_err = 0;

  logic [W+3:0] exp_q[$];
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_res;
  logic [3:0]   hold_flg;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .OPCODE(opcode), .OP1(op1), .OP2(op2), .out_valid(out_valid),
    .out_ready(out_ready), .RESULT(result), .FLAGS(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model built from integer arithmetic: {result, Z, N, C, V}.
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a_in,
                                         input logic [W-1:0] b_in);
    int a, b, r, c, v, sa, sb, sr, p;
    int full = 1 << W;
    int smax = (1 << (W - 1)) - 1;
    int smin = -(1 << (W - 1));
    logic [W-1:0] rv;
    a = int'(a_in);
    b = int'(b_in);
    sa = (a > smax) ? a - full : a;
    sb = (b > smax) ? b - full : b;
    r = 0; c = 0; v = 0;
    case (op)
      3'd0: begin r = a + b; c = int'(r >= full); sr = sa + sb; v = int'(sr > smax || sr < smin); end
      3'd1: begin r = a - b + full; c = int'(a < b); sr = sa - sb; v = int'(sr > smax || sr < smin); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        if (b < W) begin r = a << b; c = (b == 0) ? 0 : ((a >> (W - b)) & 1); end
        else if (b == W) c = a & 1;
      end
      3'd6: begin
        if (b < W) begin r = a >> b; c = (b == 0) ? 0 : ((a >> (b - 1)) & 1); end
        else if (b == W) c = (a >> (W - 1)) & 1;
      end
      default: begin p = a * b; r = p; v = int'(p >= full); end
    endcase
    r = r & (full - 1);
    rv = r[W-1:0];
    return {rv, (rv == '0), rv[W-1], c[0], v[0]};
  endfunction

  task automatic push_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back(model(op, a, b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    opcode = op;
    op1 = a;
    op2 = b;
    in_valid = 1'b1;
  endtask

  // Presents one request and returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic done = 1'b0;
    drive(op, a, b);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(op, a, b);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("send_accept", {31'd0, done}, 32'd1);
  endtask

  always @(negedge clk) begin
    logic [W+3:0] e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_ov", {31'd0, out_valid}, 32'd1);
        chk("hold_res", {28'd0, result}, {28'd0, hold_res});
        chk("hold_flg", {28'd0, flags}, {28'd0, hold_flg});
      end
      hold_prev = out_valid && !out_ready;
      hold_res  = result;
      hold_flg  = flags;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_res", {28'd0, result}, {28'd0, e[W+3:4]});
          chk("sb_flg", {28'd0, flags}, {28'd0, e[3:0]});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [2:0]   tv_op[7] = '{3'd6, 3'd5, 3'd6, 3'd1, 3'd0, 3'd7, 3'd7};
    logic [W-1:0] tv_a[7]  = '{4'b1001, 4'b1001, 4'b1000, 4'b0000, 4'b1111, 4'b1111, 4'b0011};
    logic [W-1:0] tv_b[7]  = '{4'd4, 4'd5, 4'd0, 4'b0001, 4'b0001, 4'b1111, 4'b0101};
    logic acc_d;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_res", {28'd0, result}, 32'd0);
    chk("rst_flg", {28'd0, flags}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    tick();

    // ADD 0100 + 1010
    send(3'd0, 4'b0100, 4'b1010);
    @(negedge clk);
    chk("add_ov", {31'd0, out_valid}, 32'd1);
    chk("add_res", {28'd0, result}, 32'b1110);
    chk("add_flg", {28'd0, flags}, 32'b0100);
    tick();

    // MUL 0100 * 1010: busy for WIDTH cycles, then valid
    send(3'd7, 4'b0100, 4'b1010);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("mul_busy_ov", {31'd0, out_valid}, 32'd0);
      chk("mul_busy_rdy", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("mul_ov", {31'd0, out_valid}, 32'd1);
    chk("mul_res", {28'd0, result}, 32'b1000);
    chk("mul_flg", {28'd0, flags}, 32'b0101);
    tick();

    // SUB 1000 - 0001 held with out_ready low
    out_ready = 1'b0;
    send(3'd1, 4'b1000, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sub_ov", {31'd0, out_valid}, 32'd1);
      chk("sub_rdy", {31'd0, in_ready}, 32'd0);
      chk("sub_res", {28'd0, result}, 32'b0111);
      chk("sub_flg", {28'd0, flags}, 32'b0001);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("sub_rel_rdy", {31'd0, in_ready}, 32'd1);
    tick();

    // Back-to-back XOR then SHL by WIDTH
    drive(3'd4, 4'b1111, 4'b0101);
    @(negedge clk);
    chk("b2b_rdy0", {31'd0, in_ready}, 32'd1);
    push_exp(3'd4, 4'b1111, 4'b0101);
    tick();
    drive(3'd5, 4'b0011, 4'b0100);
    @(negedge clk);
    chk("b2b_ov0", {31'd0, out_valid}, 32'd1);
    chk("b2b_res0", {28'd0, result}, 32'b1010);
    chk("b2b_rdy1", {31'd0, in_ready}, 32'd1);
    push_exp(3'd5, 4'b0011, 4'b0100);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ov1", {31'd0, out_valid}, 32'd1);
    chk("b2b_res1", {28'd0, result}, 32'b0000);
    chk("b2b_flg1", {28'd0, flags}, 32'b1010);
    tick();

    // Reset two cycles into MUL, with a competing request during reset
    send(3'd3, 4'b1001, 4'b0110);
    tick();
    send(3'd7, 4'b0100, 4'b1010);
    tick();
    rst = 1'b1;
    drive(3'd0, 4'b0001, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    chk("abort_ov", {31'd0, out_valid}, 32'd0);
    chk("abort_res", {28'd0, result}, 32'd0);
    chk("abort_flg", {28'd0, flags}, 32'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_rdy", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < W + 2; k++) begin
      tick();
      @(negedge clk);
      chk("abort_quiet", {31'd0, out_valid}, 32'd0);
    end
    tick();

    // Shift, borrow, carry and multiply-overflow boundaries
    for (int i = 0; i < 7; i++) begin
      send(tv_op[i], tv_a[i], tv_b[i]);
    end

    // Random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc_d = in_valid && in_ready;
      if (acc_d) push_exp(opcode, op1, op2);
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc_d || !in_valid) begin
        if ($urandom_range(0, 3) != 0)
          drive(3'($urandom_range(0, 7)), W'($urandom_range(0, (1 << W) - 1)),
                W'($urandom_range(0, (1 << W) - 1)));
        else
          in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4 * W + 10; c++) begin
      @(negedge clk);
      acc_d = in_valid && in_ready;
      if (acc_d) push_exp(opcode, op1, op2);
      tick();
      if (acc_d) in_valid = 1'b0;
    end
    chk("drain_q", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), width of the shift-amount field taken from OP2[SHW-1:0].
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port OPCODE  input  3  operation select.
REQ-008 SHALL have port OP1  input  WIDTH  first operand.
REQ-009 SHALL have port OP2  input  WIDTH  second operand / shift amount.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port RESULT  output  WIDTH  registered result.
REQ-013 SHALL have port FLAGS  output  4  registered {Z, N, C, V}: zero, negative (MSB), carry/borrow, signed overflow.

Function
REQ-014 Accept SHALL occur on a rising edge where in_valid && in_ready; OPCODE/OP1/OP2 are sampled only then.
REQ-015 FSM SHALL have states IDLE, MUL, HOLD; in_ready = (IDLE) || (HOLD && out_ready); out_valid = (HOLD).
REQ-016 Opcodes SHALL be: 000 ADD, 001 SUB (OP1-OP2), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (low WIDTH bits of unsigned product).
REQ-017 Accept of a non-MUL op SHALL register RESULT/FLAGS and enter HOLD on the same edge (out_valid visible 1 cycle after accept).
REQ-018 Accept of MUL SHALL load an iterative shift-add engine and a cycle counter cleared to 0, and enter MUL.
REQ-019 In MUL the engine SHALL process one multiplier bit per cycle; after exactly WIDTH cycles in MUL it SHALL write RESULT/FLAGS and enter HOLD (out_valid visible WIDTH cycles after accept).
REQ-020 In HOLD, RESULT and FLAGS SHALL stay stable while out_ready=0.
REQ-021 In HOLD with out_ready=1 and no new accept, state SHALL go to IDLE; with out_ready=1 and a simultaneous accept, the new operation SHALL be processed as if accepted from IDLE (back-to-back throughput of 1 op/cycle for non-MUL).
REQ-022 Z SHALL be 1 iff RESULT==0; N SHALL equal RESULT[WIDTH-1].
REQ-023 C SHALL be the carry-out for ADD, the borrow (OP1<OP2 unsigned) for SUB, the last bit shifted out for SHL/SHR (0 if shift amount is 0), and 0 otherwise.
REQ-024 V SHALL be two's-complement overflow for ADD/SUB, 1 for MUL iff any product bit above WIDTH-1 is nonzero, 0 otherwise.
REQ-025 Shift amount SHALL be OP2 interpreted unsigned; if OP2 >= WIDTH, RESULT SHALL be 0 and C SHALL be the bit at position 0 (SHL) or WIDTH-1 (SHR) only when OP2==WIDTH, else 0.
REQ-026 in_valid during MUL SHALL be ignored (in_ready=0); no request is lost or queued.

Reset
REQ-027 While rst=1 on a rising edge: state IDLE, RESULT=0, FLAGS=0, out_valid=0, counter=0; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-028 rst asserted during MUL or HOLD SHALL abort the operation; no result is ever emitted for it.
REQ-029 rst SHALL take priority over any simultaneous accept.

Verification (WIDTH=4)
REQ-030 ADD OP1=0100, OP2=1010 -> next cycle out_valid=1, RESULT=1110, FLAGS Z0 N1 C0 V0.
REQ-031 MUL OP1=0100, OP2=1010 -> out_valid exactly 4 cycles after accept, RESULT=1000, V=1, C=0; in_ready=0 throughout MUL.
REQ-032 SUB OP1=1000, OP2=0001 with out_ready=0 for 3 cycles -> RESULT=0111, C0 V1 held stable, in_ready=0 until out_ready=1.
REQ-033 Back-to-back XOR 1111^0101 then SHL 0011<<0100, out_ready=1 -> results 1010 then 0000 (C=1) on consecutive cycles.
REQ-034 rst=1 two cycles into MUL -> next cycle out_valid=0, RESULT=0000, FLAGS=0000, in_ready=1 after release.
REQ-035 Formal: out_valid never rises without a prior accept since reset; RESULT/FLAGS stable while out_valid && !out_ready.
